// File: rtl/cart_upload_if.sv
// HPS upload handshake plus cart RAM read port, grouped for cart_upload_reader.
// The slave modport is the reader; the master modport is the HPS/RAM side.
interface cart_upload_if #(
    parameter int AW = 13
) ();
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [15:0]   ioctl_din;
    logic          ioctl_wait;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_q;
    logic [AW:0]   mem_size;

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_q, mem_size,
        output ioctl_din, ioctl_wait, mem_addr, mem_rd
    );

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_q, mem_size,
        input  ioctl_din, ioctl_wait, mem_addr, mem_rd
    );
endinterface

// File: rtl/cart_upload_reader.sv
// Serves HPS upload word reads from a byte-wide cart RAM, padding past mem_size with 8'hFF.
// Optional running byte checksum of returned words: define UPLOAD_CHECKSUM_EN.
module cart_upload_reader #(
    parameter int         AW           = 13,
    parameter logic [7:0] UPLOAD_INDEX = 8'd1
) (
    input  logic           clk_sys,
    input  logic           reset,
    cart_upload_if.slave   bus,
    output logic [15:0]    checksum
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] FILL = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [24:0]   addr_q, addr_d;
    logic [7:0]    lo_q, lo_d;
    logic [15:0]   din_q, din_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    logic          start;
    logic [24:0]   addr_hi;
    logic [24:0]   size_ext;
    logic [7:0]    lo_byte;
    logic [7:0]    hi_byte;
    logic          unused_addr_bit;

    assign unused_addr_bit = bus.ioctl_addr[0];

    assign start    = bus.ioctl_rd && bus.ioctl_upload && (bus.ioctl_index == UPLOAD_INDEX);
    // addr_q is always even, so setting bit 0 is the +1 without a carry chain.
    assign addr_hi  = addr_q | 25'd1;
    assign size_ext = 25'(bus.mem_size);
    assign lo_byte  = (addr_q  >= size_ext) ? 8'hFF : bus.mem_q;
    assign hi_byte  = (addr_hi >= size_ext) ? 8'hFF : bus.mem_q;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned and infers a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        lo_d       = lo_q;
        din_d      = din_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = {bus.ioctl_addr[24:1], 1'b0};
                    mem_addr_d = addr_d[AW-1:0];
                    state_d    = LO;
                end
            end
            LO: begin
                if (!bus.ioctl_upload) begin
                    state_d = IDLE;
                end else begin
                    mem_addr_d = addr_hi[AW-1:0];
                    state_d    = HI;
                end
            end
            HI: begin
                if (!bus.ioctl_upload) begin
                    state_d = IDLE;
                end else begin
                    lo_d    = lo_byte;
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
                if (bus.ioctl_upload) begin
                    din_d = {hi_byte, lo_q};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            lo_q       <= '0;
            din_q      <= '0;
            mem_addr_q <= '0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            addr_q     <= addr_d;
            lo_q       <= lo_d;
            din_q      <= din_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.ioctl_din  = din_q;
    assign bus.ioctl_wait = (state_q != IDLE);
    assign bus.mem_rd     = (state_q == LO) || (state_q == HI);
    assign bus.mem_addr   = mem_addr_q;

`ifdef UPLOAD_CHECKSUM_EN
    logic        upload_q;
    logic [15:0] sum_q;
    logic        word_done;

    assign word_done = (state_q == FILL) && bus.ioctl_upload;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            upload_q <= 1'b0;
            sum_q    <= '0;
        end else begin
            upload_q <= bus.ioctl_upload;
            if (bus.ioctl_upload && !upload_q) begin
                sum_q <= '0;
            end else if (word_done) begin
                sum_q <= sum_q + 16'(lo_q) + 16'(hi_byte);
            end
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule
